// File: rtl/control_puerta.sv
// control_puerta: door-sequencing controller.
// Conditions the raw board inputs (2-FF synchronizers, per-button debounce,
// shared request edge) and runs a single Moore state machine that drives the
// door motor.
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   btn_in/btn_out raw inside/outside buttons (active-high)
//   fc_abierta     fully-open limit switch
//   fc_cerrada     fully-closed limit switch
//   obstaculo      obstacle sensor
//   motor_abrir    drive motor in the open direction
//   motor_cerrar   drive motor in the close direction
//   puerta_abierta high while the door is held open
//   falla          high while faulted
//   estado         state code (CERRADA=0 .. FALLA=4)
module control_puerta #(
  parameter int unsigned DEB_CYC = 4,
  parameter int unsigned T_OPEN  = 20,
  parameter int unsigned T_MOVE  = 50,
  parameter int unsigned CW      = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_in,
  input  logic       btn_out,
  input  logic       fc_abierta,
  input  logic       fc_cerrada,
  input  logic       obstaculo,
  output logic       motor_abrir,
  output logic       motor_cerrar,
  output logic       puerta_abierta,
  output logic       falla,
  output logic [2:0] estado
);

  typedef enum logic [2:0] {
    CERRADA  = 3'd0,
    ABRIENDO = 3'd1,
    ABIERTA  = 3'd2,
    CERRANDO = 3'd3,
    FALLA    = 3'd4
  } state_t;

  localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYC - 1);
  localparam logic [CW-1:0] OPEN_LOAD = CW'(T_OPEN);
  localparam logic [CW-1:0] MOVE_LOAD = CW'(T_MOVE);
  localparam logic [CW-1:0] ONE       = CW'(1);

  // Input synchronizers: {btn_in, btn_out, fc_abierta, fc_cerrada, obstaculo}
  logic [4:0] sync1, sync2;
  logic [1:0] s_btn;
  logic       s_fca, s_fcc, s_obs;
  logic [1:0] rise;
  logic       req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {btn_in, btn_out, fc_abierta, fc_cerrada, obstaculo};
      sync2 <= sync1;
    end
  end

  assign s_btn = sync2[4:3];
  assign s_fca = sync2[2];
  assign s_fcc = sync2[1];
  assign s_obs = sync2[0];

  // One debouncer per button. The counter tracks consecutive cycles in which
  // the synchronized level disagrees with the debounced one.
  for (genvar g = 0; g < 2; g++) begin : g_deb
    logic          deb, deb_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        deb   <= 1'b0;
        deb_q <= 1'b0;
        cnt   <= '0;
      end else begin
        deb_q <= deb;
        if (s_btn[g] != deb) begin
          if (cnt == DEB_LAST) begin
            deb <= s_btn[g];
            cnt <= '0;
          end else begin
            cnt <= cnt + ONE;
          end
        end else begin
          cnt <= '0;
        end
      end
    end

    assign rise[g] = deb & ~deb_q;
  end

  // Simultaneous edges on both buttons collapse into one request.
  assign req = |rise;

  // Single timer shared by the move and hold phases (never active together).
  state_t        state, state_nx;
  logic [CW-1:0] tmr, tmr_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CERRADA;
      tmr   <= '0;
    end else begin
      state <= state_nx;
      tmr   <= tmr_nx;
    end
  end

  // The move timer holds the motor cycles still allowed including the current
  // one, so a value of 1 without a limit switch means this is the last cycle:
  // the motor is high for exactly T_MOVE cycles.
  always_comb begin
    state_nx = state;
    tmr_nx   = tmr;
    if (s_fca && s_fcc) begin
      state_nx = FALLA;
    end else begin
      case (state)
        CERRADA: begin
          if (req) begin
            state_nx = ABRIENDO;
            tmr_nx   = MOVE_LOAD;
          end
        end
        ABRIENDO: begin
          if (s_fca) begin
            state_nx = ABIERTA;
            tmr_nx   = OPEN_LOAD;
          end else if (tmr <= ONE) begin
            state_nx = FALLA;
          end else begin
            tmr_nx = tmr - ONE;
          end
        end
        ABIERTA: begin
          if (req || s_obs) begin
            tmr_nx = OPEN_LOAD;
          end else if (tmr == '0) begin
            state_nx = CERRANDO;
            tmr_nx   = MOVE_LOAD;
          end else begin
            tmr_nx = tmr - ONE;
          end
        end
        CERRANDO: begin
          if (s_obs || req) begin
            state_nx = ABRIENDO;
            tmr_nx   = MOVE_LOAD;
          end else if (s_fcc) begin
            state_nx = CERRADA;
          end else if (tmr <= ONE) begin
            state_nx = FALLA;
          end else begin
            tmr_nx = tmr - ONE;
          end
        end
        FALLA:   state_nx = FALLA;
        default: state_nx = FALLA;
      endcase
    end
  end

  always_comb begin
    motor_abrir    = 1'b0;
    motor_cerrar   = 1'b0;
    puerta_abierta = 1'b0;
    falla          = 1'b0;
    case (state)
      ABRIENDO: motor_abrir    = 1'b1;
      ABIERTA:  puerta_abierta = 1'b1;
      CERRANDO: motor_cerrar   = 1'b1;
      FALLA:    falla          = 1'b1;
      default:  ;
    endcase
  end

  assign estado = state;

endmodule

// File: doc/control_puerta.md
# control_puerta

Door-sequencing controller for the access-control project. Takes the inside and outside push buttons, the two limit switches and the obstacle sensor, and drives the door motor. Both buttons share a single open request. A single state machine decides when the door opens, how long it stays open, when it reverses, and when it faults. It sits between the raw board inputs and the motor driver outputs.

## Interface
- DEB_CYC, 4: cycles a synchronized button level must be stable before the debounced level changes (≥1)
- T_OPEN, 20: cycles the door is held open after the last request/obstacle (≥1)
- T_MOVE, 50: maximum motor run cycles per movement before fault (≥1)
- CW, 16: width of all internal counters; every parameter must be < 2^CW
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- btn_in  in  1  inside button, raw, active-high, asynchronous
- btn_out  in  1  outside button, raw, active-high, asynchronous
- fc_abierta  in  1  fully-open limit switch, active-high, asynchronous
- fc_cerrada  in  1  fully-closed limit switch, active-high, asynchronous
- obstaculo  in  1  obstacle sensor, active-high, asynchronous
- motor_abrir  out  1  drive motor in the open direction
- motor_cerrar  out  1  drive motor in the close direction
- puerta_abierta  out  1  high while in ABIERTA
- falla  out  1  high while in FALLA
- estado  out  3  state code: CERRADA=0, ABRIENDO=1, ABIERTA=2, CERRANDO=3, FALLA=4

## Operation
- Input conditioning:
  - All five inputs pass through a 2-FF synchronizer.
  - Each button has its own debouncer. The debounced level flips once the synchronized value has differed from it for DEB_CYC consecutive cycles. Any agreeing cycle clears the count.
  - A rising edge of either debounced button gives a one-cycle request pulse `req`. Simultaneous edges on both buttons count as one request.
- State machine, one register, outputs decoded from the state only (Moore):
  - CERRADA: motors off.
    - `req` → ABRIENDO, load the move timer with T_MOVE.
  - ABRIENDO: motor_abrir=1.
    - Synchronized fc_abierta → ABIERTA, load the hold timer with T_OPEN.
    - Otherwise the move timer decrements. When it reaches 0 → FALLA.
    - `req` and obstaculo are ignored.
  - ABIERTA: puerta_abierta=1.
    - `req` or obstaculo reloads the hold timer with T_OPEN. Otherwise it decrements.
    - Hold timer at 0 and no obstaculo → CERRANDO, load the move timer with T_MOVE.
  - CERRANDO: motor_cerrar=1.
    - obstaculo or `req` → ABRIENDO (reversal), reload the move timer.
    - Else fc_cerrada → CERRADA.
    - Else decrement. When the timer reaches 0 → FALLA.
  - FALLA: motors off, falla=1. Only rst_n exits this state.
- Priority within one cycle, highest first:
  1. Both limit switches high → FALLA, from any state.
  2. Reversal (CERRANDO only).
  3. Limit switch.
  4. Timeout.
- motor_abrir and motor_cerrar are never high together.
- A stuck button does not re-trigger. It must be released (debounced low) before it can request again.

## Timing
- Reset, asynchronous and immediate:
  - estado=0 (CERRADA); all outputs 0.
  - Synchronizers, debounced levels and timers cleared.
  - Reset mid-movement drops the motor outputs in the same instant.
- Request latency: btn_in rising, sampled high at edge k and held → motor_abrir high after edge k+DEB_CYC+3.
  - This is 2 synchronizer cycles, DEB_CYC debounce cycles and 1 state register cycle.
- Limit/obstacle latency: input sampled at edge k → state changes after edge k+3.
  - This is 2 synchronizer cycles plus 1 state register cycle.
- Move timeout: with no limit switch, the motor output is high for exactly T_MOVE cycles, then estado=4.
- Hold time: with no request or obstacle, puerta_abierta is high for exactly T_OPEN+1 cycles before motor_cerrar asserts.
- A limit switch arriving in the same cycle the timer reaches 0 wins; no fault.

## Test plan
- Reset with defaults, pulse btn_out for 10 cycles, fc_abierta 5 cycles after motor_abrir, fc_cerrada 5 cycles after motor_cerrar:
  - motor_abrir at k+7.
  - puerta_abierta for 21 cycles.
  - Sequence closes through estado 0→1→2→3→0.
- Bounce btn_in high/low for runs of 3 cycles, then hold high:
  - Exactly one open sequence.
  - No motor output until 4 stable high cycles after the input settles.
- Obstacle asserted during CERRANDO:
  - motor_cerrar drops and motor_abrir rises 3 cycles after obstaculo.
  - estado goes 3→1.
  - Assert fc_abierta: hold timer restarts at T_OPEN.
- Never assert fc_abierta after a request:
  - motor_abrir high exactly 50 cycles.
  - Then estado=4, falla=1, motors 0.
  - Further button presses are ignored.
  - rst_n low returns estado=0.
- fc_abierta and fc_cerrada high together while CERRADA → FALLA 3 cycles later.
- rst_n asserted mid-ABRIENDO: motor_abrir=0 immediately, without waiting for a clock; estado=0.
